// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns: mixes COLS_PER_CYCLE columns per clock over N cycles, or passes the
// state through unmixed for the final round. One block in flight; result held until accepted.
module mix_columns_seq #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [0:127] word,
   input  logic         last_round,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:127] mixed,
   output logic         busy
);

   localparam int N = 4 / COLS_PER_CYCLE;
   localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] LAST_CNT = 2'((N - 1) * COLS_PER_CYCLE);

   generate
      if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
         $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t       state_q, state_d;
   logic [0:127] work_q, work_d;
   logic         last_q, last_d;
   logic [1:0]   cnt_q, cnt_d;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // One column: a0 is the lowest byte index, i.e. the leftmost byte of the slice.
   function automatic logic [0:31] mix_col(input logic [0:31] c);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] r0, r1, r2, r3;
      a0 = c[0:7];
      a1 = c[8:15];
      a2 = c[16:23];
      a3 = c[24:31];
      r0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
      r1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
      r2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
      r3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
      return {r0, r1, r2, r3};
   endfunction

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               work_d  = word;
               last_d  = last_round;
               cnt_d   = 2'd0;
               state_d = CALC;
            end
         end
         CALC: begin
            if (last_q) begin
               state_d = DONE;
            end else begin
               for (int j = 0; j < COLS_PER_CYCLE; j++) begin
                  logic [1:0] col;
                  col = cnt_q + 2'(j);
                  work_d[{col, 5'b0} +: 32] = mix_col(work_q[{col, 5'b0} +: 32]);
               end
               cnt_d = cnt_q + STEP;
               if (cnt_q == LAST_CNT) state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         work_q  <= '0;
         last_q  <= 1'b0;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // in_ready is gated by rst_n so nothing is offered while reset is held.
   assign in_ready  = rst_n & (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign mixed     = work_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: three instances (1, 2 and 4 columns per cycle) share one stimulus,
// each checked every cycle against a GF(2^8) matrix model plus literal vectors.
module tb_mix_columns_seq;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic [0:127] word;
   logic         last_round;
   logic         out_ready;
   logic [2:0]   in_ready_w, out_valid_w, busy_w;
   logic [0:127] mixed_w [3];

   int tests = 0;
   int fails = 0;

   localparam logic [0:127] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [0:127] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
   localparam logic [0:127] COLV_IN  = 128'hdb13534501010101c6c6c6c6d4d4d4d5;
   localparam logic [0:127] COLV_OUT = 128'h8e4da1bc01010101c6c6c6c6d5d5d7d6;
   localparam logic [0:127] COL2_IN  = 128'h2d26314c01010101c6c6c6c6d4d4d4d5;
   localparam logic [0:127] COL2_OUT = 128'h4d7ebdf801010101c6c6c6c6d5d5d7d6;
   localparam logic [0:127] BYP_IN   = 128'h3bd92268fc74fb735767cbe0c0590e2d;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .in_valid   (in_valid),
         .in_ready   (in_ready_w[g]),
         .word       (word),
         .last_round (last_round),
         .out_valid  (out_valid_w[g]),
         .out_ready  (out_ready),
         .mixed      (mixed_w[g]),
         .busy       (busy_w[g])
      );
   end

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in;
      b = b_in;
      p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) p ^= a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = b >> 1;
      end
      return p;
   endfunction

   // State x circulant matrix (rows are rotations of 2 3 1 1), one column at a time.
   function automatic logic [0:127] mix_model(input logic [0:127] w, input logic lr);
      logic [0:127] r;
      logic [7:0]   acc;
      logic [7:0]   coef [4];
      coef = '{8'd2, 8'd3, 8'd1, 8'd1};
      if (lr) return w;
      for (int c = 0; c < 4; c++) begin
         for (int rr = 0; rr < 4; rr++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++)
               acc ^= gmul(coef[(k - rr + 4) % 4], w[(c * 4 + k) * 8 +: 8]);
            r[(c * 4 + rr) * 8 +: 8] = acc;
         end
      end
      return r;
   endfunction

   function automatic int lat_of(input int i, input logic lr);
      return lr ? 1 : (4 >> i);
   endfunction

   // Transaction-level model: per instance, a pending block and the edge count when it is due.
   int           ecount = 0;
   logic         pending  [3];
   int           done_e   [3];
   logic [0:127] exp_res  [3];
   logic [0:127] last_res [3];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            pending[i]  <= 1'b0;
            last_res[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (pending[i] && ecount >= done_e[i] && out_ready) begin
               pending[i]  <= 1'b0;
               last_res[i] <= exp_res[i];
            end else if (!pending[i] && in_valid) begin
               pending[i] <= 1'b1;
               exp_res[i] <= mix_model(word, last_round);
               done_e[i]  <= ecount + 1 + lat_of(i, last_round);
            end
         end
         ecount <= ecount + 1;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 3; i++) begin
            logic vexp;
            vexp = pending[i] && (ecount >= done_e[i]);
            chk($sformatf("in_ready[%0d]", i), in_ready_w[i], !pending[i]);
            chk($sformatf("out_valid[%0d]", i), out_valid_w[i], vexp);
            chk($sformatf("busy[%0d]", i), busy_w[i], pending[i]);
            if (vexp)
               chk($sformatf("mixed[%0d]", i), mixed_w[i], exp_res[i]);
            else if (!pending[i])
               chk($sformatf("mixed_hold[%0d]", i), mixed_w[i], last_res[i]);
         end
      end
   end

   task automatic run_vec(input string nm, input logic [0:127] w, input logic lr,
                          input logic [0:127] lit);
      int first [3];
      for (int i = 0; i < 3; i++) first[i] = -1;
      @(posedge clk); #2;
      word = w; last_round = lr; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #2;
      in_valid = 1'b0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (first[i] < 0 && out_valid_w[i]) begin
               first[i] = j;
               chk($sformatf("%s_lit[%0d]", nm, i), mixed_w[i], lit);
            end
         end
      end
      for (int i = 0; i < 3; i++)
         chk($sformatf("%s_latency[%0d]", nm, i), 128'(first[i]), 128'(lat_of(i, lr)));
   endtask

   initial begin
      int h, a;
      logic dropped;
      logic [0:127] outs [$];

      rst_n = 1'b0; in_valid = 1'b0; word = '0; last_round = 1'b0; out_ready = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_in_ready[%0d]", i), in_ready_w[i], 1'b0);
         chk($sformatf("rst_out_valid[%0d]", i), out_valid_w[i], 1'b0);
         chk($sformatf("rst_busy[%0d]", i), busy_w[i], 1'b0);
         chk($sformatf("rst_mixed[%0d]", i), mixed_w[i], 128'h0);
      end

      chk("model_fips", mix_model(FIPS_IN, 1'b0), FIPS_OUT);
      chk("model_colv", mix_model(COLV_IN, 1'b0), COLV_OUT);
      chk("model_col2", mix_model(COL2_IN, 1'b0), COL2_OUT);
      chk("model_byp",  mix_model(BYP_IN, 1'b1), BYP_IN);

      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      run_vec("fips", FIPS_IN, 1'b0, FIPS_OUT);
      run_vec("colv", COLV_IN, 1'b0, COLV_OUT);
      run_vec("col2", COL2_IN, 1'b0, COL2_OUT);
      run_vec("byp",  BYP_IN,  1'b1, BYP_IN);

      // Backpressure: stall in DONE while a second request waits.
      @(posedge clk); #2;
      word = FIPS_IN; last_round = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #2;
      word = BYP_IN; last_round = 1'b1;
      h = -1;
      for (int j = 0; j < 20 && h < 0; j++) begin
         @(negedge clk);
         if (out_valid_w[0]) h = j;
      end
      chk("bp_valid_seen", 128'(h >= 0), 128'(1));
      repeat (10) begin
         @(negedge clk);
         chk("bp_valid_hold", out_valid_w[0], 1'b1);
         chk("bp_mixed_hold", mixed_w[0], FIPS_OUT);
         chk("bp_ready_low", in_ready_w[0], 1'b0);
      end
      @(posedge clk); #2;
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid_clear", out_valid_w[0], 1'b0);
      chk("bp_ready_back", in_ready_w[0], 1'b1);
      chk("bp_busy_clear", busy_w[0], 1'b0);

      // Asynchronous reset two edges after accept.
      @(posedge clk); #2;
      word = FIPS_IN; last_round = 1'b0; in_valid = 1'b1;
      @(posedge clk); #2;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("arst_out_valid[%0d]", i), out_valid_w[i], 1'b0);
         chk($sformatf("arst_busy[%0d]", i), busy_w[i], 1'b0);
         chk($sformatf("arst_mixed[%0d]", i), mixed_w[i], 128'h0);
         chk($sformatf("arst_in_ready[%0d]", i), in_ready_w[i], 1'b0);
      end
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (8) @(posedge clk);
      run_vec("post_rst", FIPS_IN, 1'b0, FIPS_OUT);

      // Back-to-back: in_valid held across two blocks.
      @(posedge clk); #2;
      word = FIPS_IN; last_round = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #2;
      word = COLV_IN;
      h = -1; a = -1; dropped = 1'b0;
      for (int j = 0; j < 30; j++) begin
         @(negedge clk);
         if (out_valid_w[0]) outs.push_back(mixed_w[0]);
         if (h < 0 && out_valid_w[0] && out_ready) h = j;
         else if (h >= 0 && a < 0 && in_ready_w[0] && in_valid) a = j;
         if (a >= 0 && !dropped) begin
            @(posedge clk); #2;
            in_valid = 1'b0;
            dropped = 1'b1;
         end
      end
      chk("b2b_count", 128'(outs.size()), 128'(2));
      if (outs.size() >= 2) begin
         chk("b2b_first", outs[0], FIPS_OUT);
         chk("b2b_second", outs[1], COLV_OUT);
      end
      chk("b2b_spacing", 128'(a - h), 128'(1));

      repeat (4) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, %0d tests run", tests);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Iterative AES MixColumns stage that sits directly downstream of ShiftRows. It consumes the 128-bit shifted state and produces the mixed state for AddRoundKey.
- Processes COLS_PER_CYCLE columns per clock, which trades area against latency.
- Uses valid/ready handshakes on both sides.
- A per-block last_round flag bypasses mixing, as required for the final AES round.

Parameters:
- COLS_PER_CYCLE, 1, columns mixed per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.
- N (localparam), 4/COLS_PER_CYCLE, number of compute cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream (ShiftRows) state valid
- in_ready  output  1  block can accept a state
- word  input  [0:127]  shifted state. Byte k = bits [8k:8k+7]; column c = bytes 4c..4c+3; bit 0 of each byte is its MSB.
- last_round  input  1  sampled with word; 1 = pass through unmixed
- out_valid  output  1  mixed result valid
- out_ready  input  1  downstream accepts result
- mixed  output  [0:127]  result, same byte/column ordering as word
- busy  output  1  high in CALC or DONE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; out_valid = 0; mixed = 0; busy = 0; column counter = 0.
  - in_ready is forced 0 while rst_n is low.
  - A reset asserted mid-CALC or mid-DONE discards the block; nothing is emitted after release.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready = 1. On in_valid & in_ready at edge E0: capture word into the working register, capture last_round, counter = 0, go to CALC.
  - CALC, normal (last_round = 0): at each edge, replace columns counter .. counter+COLS_PER_CYCLE-1 with their mixed values, then counter += COLS_PER_CYCLE. At the edge where the final column group is written, go to DONE.
  - CALC, bypass (last_round = 1): one cycle, data unchanged, go to DONE.
  - DONE: out_valid = 1, mixed = working register (stable). On out_valid & out_ready: go to IDLE and clear out_valid at that edge.
- Latency:
  - out_valid rises at edge E0+N (normal) or E0+1 (bypass).
  - in_ready is 0 throughout CALC and DONE; there is no overlap between blocks.
  - Minimum spacing between accepts is N+2 cycles when out_ready is held high.
- Backpressure: with out_ready low, stay in DONE indefinitely; mixed and out_valid are held.
- in_valid while busy is ignored; word is not sampled. Upstream must hold word until in_ready.
- Arithmetic, GF(2^8) with polynomial 0x11B:
  - xtime(b) = (b<<1) ^ (b[MSB] ? 0x1B : 0x00), truncated to 8 bits.
  - For column bytes a0..a3 (a0 = lowest byte index):
    - r0 = 2a0^3a1^a2^a3
    - r1 = a0^2a1^3a2^a3
    - r2 = a0^a1^2a2^3a3
    - r3 = 3a0^a1^a2^2a3
  - 3a = xtime(a)^a.
  - Purely combinational per column, with no carry between columns.
- Working register is the only data storage. mixed is driven from it, so it has no reset-dependent glitches after the first block.

Test Plan:
- FIPS-197 round 1, COLS_PER_CYCLE=1: word=d4bf5d30e0b452aeb84111f11e2798e5, last_round=0 -> mixed=046681e5e0cb199a48f8d37a2806264c; out_valid rises exactly 4 cycles after the accept edge.
- Column vectors, COLS_PER_CYCLE=4: word=db1353450101010_1c6c6c6c6d4d4d4d5 (written as db135345 01010101 c6c6c6c6 d4d4d4d5) -> mixed=8e4da1bc01010101c6c6c6c6d5d5d7d6; latency 1 cycle. Repeat with COLS_PER_CYCLE=2 (latency 2) and 2d26314c in column 0 -> column 0 = 4d7ebdf8.
- Bypass: word=3bd92268fc74fb735767cbe0c0590e2d, last_round=1 -> mixed equals word; out_valid rises 1 cycle after accept.
- Backpressure: out_ready held low 10 cycles after out_valid -> out_valid stays 1, mixed is stable, in_ready stays 0, and a second in_valid is not accepted. Then raise out_ready -> handshake in one cycle, IDLE next, in_ready = 1.
- Reset mid-CALC: assert rst_n=0 two cycles after accept (COLS_PER_CYCLE=1) -> out_valid, mixed and busy go to 0 immediately, asynchronously. After release no output appears, and the next vector computes correctly.
- Back-to-back: in_valid held high with two FIPS states and out_ready=1 -> the two results appear in order, the second accept occurs the cycle after the first output handshake, and both match their expected values.
